// File: rtl/layer_0_pixel_packer.sv
// Packs CHANNELS input words into one pixel and streams the zero-bordered
// P x P image in raster order, pacing emission itself (no downstream stall).
module layer_0_pixel_packer #(
  parameter int DATA_WIDTH = 32,
  parameter int CHANNELS   = 3,
  parameter int IMG_SIZE   = 416,
  parameter int PAD        = 1,
  localparam int P         = IMG_SIZE + 2 * PAD,
  localparam int CW        = (P > 1) ? $clog2(P) : 1
) (
  input  logic                           Clk,
  input  logic                           Rst,
  input  logic [DATA_WIDTH-1:0]          word_in,
  input  logic                           word_valid,
  output logic                           word_ready,
  output logic [CHANNELS*DATA_WIDTH-1:0] data_out,
  output logic                           valid_out,
  output logic                           frame_start,
  output logic                           frame_end,
  output logic [CW-1:0]                  row_out,
  output logic [CW-1:0]                  col_out
);

  localparam int CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic [1:0] {
    EMIT_PAD = 2'd0,
    COLLECT  = 2'd1,
    EMIT_PIX = 2'd2
  } state_t;

  state_t                           state;
  logic   [CW-1:0]                  row;
  logic   [CW-1:0]                  col;
  logic   [CW-1:0]                  next_row;
  logic   [CW-1:0]                  next_col;
  logic   [CHW-1:0]                 ch;
  logic   [CHANNELS*DATA_WIDTH-1:0] pix_p0;
  logic                             last_col;
  logic                             last_row;
  logic                             emit;
  logic                             last_ch;
  logic                             accept;

  function automatic logic is_border(input logic [CW-1:0] r, input logic [CW-1:0] c);
    return (int'(r) < PAD) || (int'(r) >= P - PAD) ||
           (int'(c) < PAD) || (int'(c) >= P - PAD);
  endfunction

  // Reset must block the handshake combinationally so a word offered
  // during reset is never consumed.
  assign word_ready = (state == COLLECT) && !Rst;
  assign accept     = word_valid && word_ready;
  assign emit       = (state == EMIT_PAD) || (state == EMIT_PIX);
  assign last_ch    = (ch == CHW'(CHANNELS - 1));

  always_comb begin
    last_col = (col == CW'(P - 1));
    last_row = (row == CW'(P - 1));
    next_col = last_col ? '0 : col + 1'b1;
    next_row = row;
    if (last_col) begin
      next_row = last_row ? '0 : row + 1'b1;
    end
  end

  // Stage p0: channel collection buffer (data only, no reset)
  always_ff @(posedge Clk) begin
    if (accept) begin
      pix_p0[int'(ch)*DATA_WIDTH +: DATA_WIDTH] <= word_in;
    end
  end

  // Stage p1: position walk, FSM and registered pixel output
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state       <= (PAD > 0) ? EMIT_PAD : COLLECT;
      row         <= '0;
      col         <= '0;
      ch          <= '0;
      valid_out   <= 1'b0;
      data_out    <= '0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      row_out     <= '0;
      col_out     <= '0;
    end else begin
      valid_out   <= emit;
      frame_start <= emit && (row == '0) && (col == '0);
      frame_end   <= emit && last_row && last_col;
      row_out     <= emit ? row : '0;
      col_out     <= emit ? col : '0;
      if (emit) begin
        data_out <= (state == EMIT_PIX) ? pix_p0 : '0;
        row      <= next_row;
        col      <= next_col;
        ch       <= '0;
        state    <= is_border(next_row, next_col) ? EMIT_PAD : COLLECT;
      end else if (state == COLLECT) begin
        if (accept) begin
          if (last_ch) begin
            state <= EMIT_PIX;
          end else begin
            ch <= ch + 1'b1;
          end
        end
      end else begin
        state <= EMIT_PAD;
      end
    end
  end

endmodule

// File: tb/tb_layer_0_pixel_packer.sv
// Directed bench: a padded 4x4 instance for framing, stall, reset and channel
// order, plus an unpadded 2x2 instance for back-to-back interior pacing.
module tb_layer_0_pixel_packer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rst0;
  logic [31:0] word_in, word_in0;
  logic        word_valid, word_valid0;
  logic        word_ready, word_ready0;
  logic [95:0] data_out, data_out0;
  logic        valid_out, valid_out0;
  logic        frame_start, frame_start0;
  logic        frame_end, frame_end0;
  logic [2:0]  row_out, col_out;
  logic [0:0]  row_out0, col_out0;

  layer_0_pixel_packer #(.DATA_WIDTH(32), .CHANNELS(3), .IMG_SIZE(4), .PAD(1)) dut (
    .Clk(clk), .Rst(rst), .word_in(word_in), .word_valid(word_valid),
    .word_ready(word_ready), .data_out(data_out), .valid_out(valid_out),
    .frame_start(frame_start), .frame_end(frame_end),
    .row_out(row_out), .col_out(col_out)
  );

  layer_0_pixel_packer #(.DATA_WIDTH(32), .CHANNELS(3), .IMG_SIZE(2), .PAD(0)) dut0 (
    .Clk(clk), .Rst(rst0), .word_in(word_in0), .word_valid(word_valid0),
    .word_ready(word_ready0), .data_out(data_out0), .valid_out(valid_out0),
    .frame_start(frame_start0), .frame_end(frame_end0),
    .row_out(row_out0), .col_out(col_out0)
  );

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic        last_hs, last_hs0;
  int          pulses, zeros, b2b, fs_extra, last_word_cyc, lat, idx, n;
  logic        done, prev_int, cur_int;
  logic [2:0]  fe_row, fe_col;
  logic [95:0] first_int_data;
  logic [31:0] pat [3];
  int          stall_bad;

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    last_hs  = word_valid & word_ready;
    last_hs0 = word_valid0 & word_ready0;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    rst = 1'b1; rst0 = 1'b1;
    word_valid = 1'b0; word_valid0 = 1'b0;
    word_in = 32'd1; word_in0 = 32'd1;
    pat[0] = 32'hAAAA0000; pat[1] = 32'hBBBB0000; pat[2] = 32'hCCCC0000;
    repeat (3) tick();

    check("rst_word_ready", 96'(word_ready), 96'(0));
    check("rst_valid_out", 96'(valid_out), 96'(0));
    check("rst_data_out", data_out, 96'(0));
    check("rst_frame_start", 96'(frame_start), 96'(0));
    check("rst_frame_end", 96'(frame_end), 96'(0));
    check("rst_row_col", 96'({row_out, col_out}), 96'(0));
    check("rst0_word_ready", 96'(word_ready0), 96'(0));
    check("rst0_valid_out", 96'(valid_out0), 96'(0));

    // Frame 1: words 1,2,3,... with word_valid held high
    word_valid = 1'b1;
    rst = 1'b0;
    #1;
    check("pad00_no_ready", 96'(word_ready), 96'(0));
    tick();
    check("first_valid", 96'(valid_out), 96'(1));
    check("first_frame_start", 96'(frame_start), 96'(1));
    check("first_pos", 96'({row_out, col_out}), 96'(0));
    check("first_pad_data", data_out, 96'(0));

    pulses = 1; zeros = 1; b2b = 0; fs_extra = 0; done = 1'b0;
    prev_int = 1'b0; lat = -1; last_word_cyc = 0;
    first_int_data = '0; fe_row = '0; fe_col = '0;
    for (int i = 0; i < 200 && !done; i++) begin
      tick();
      if (last_hs) begin
        last_word_cyc = cyc;
        word_in = word_in + 32'd1;
      end
      cur_int = valid_out && (row_out >= 3'd1) && (row_out <= 3'd4) &&
                (col_out >= 3'd1) && (col_out <= 3'd4);
      if (prev_int && cur_int) b2b++;
      prev_int = cur_int;
      if (valid_out) begin
        pulses++;
        if (data_out == 96'(0)) zeros++;
        if (frame_start) fs_extra++;
        if (row_out == 3'd1 && col_out == 3'd1) begin
          first_int_data = data_out;
          lat = cyc - last_word_cyc;
        end
        if (frame_end) begin
          done = 1'b1;
          fe_row = row_out;
          fe_col = col_out;
        end
      end
    end
    check("frame1_end_seen", 96'(done), 96'(1));
    check("frame1_pulses", 96'(pulses), 96'(36));
    check("frame1_zero_pixels", 96'(zeros), 96'(20));
    check("frame1_first_interior", first_int_data, {32'd3, 32'd2, 32'd1});
    check("frame1_latency", 96'(lat), 96'(1));
    check("frame1_end_pos", 96'({fe_row, fe_col}), 96'({3'd5, 3'd5}));
    check("frame1_no_b2b_interior", 96'(b2b), 96'(0));
    check("frame1_single_start", 96'(fs_extra), 96'(0));
    check("frame1_words_used", 96'(word_in), 96'(49));

    // Frame wrap: pad at (0,0) directly after the frame_end pad
    tick();
    check("wrap_valid", 96'(valid_out), 96'(1));
    check("wrap_frame_start", 96'(frame_start), 96'(1));
    check("wrap_pos", 96'({row_out, col_out}), 96'(0));
    check("wrap_data", data_out, 96'(0));

    // Stall after the second word of pixel (1,1)
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      tick();
      if (last_hs) word_in = word_in + 32'd1;
      if (word_in == 32'd51) done = 1'b1;
    end
    check("stall_reach", 96'(done), 96'(1));
    word_valid = 1'b0;
    stall_bad = 0;
    repeat (10) begin
      tick();
      if (word_ready !== 1'b1 || valid_out !== 1'b0) stall_bad++;
    end
    check("stall_hold", 96'(stall_bad), 96'(0));
    word_valid = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      tick();
      if (last_hs) word_in = word_in + 32'd1;
      if (valid_out) done = 1'b1;
    end
    check("stall_resume_seen", 96'(done), 96'(1));
    check("stall_pixel_data", data_out, {32'd51, 32'd50, 32'd49});
    check("stall_pixel_pos", 96'({row_out, col_out}), 96'({3'd1, 3'd1}));

    // Reset after two words of pixel (1,2)
    done = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      tick();
      if (last_hs) word_in = word_in + 32'd1;
      if (word_in == 32'd54) done = 1'b1;
    end
    check("midreset_reach", 96'(done), 96'(1));
    rst = 1'b1;
    #1;
    check("midreset_ready_low", 96'(word_ready), 96'(0));
    tick();
    check("midreset_valid", 96'(valid_out), 96'(0));
    check("midreset_data", data_out, 96'(0));
    check("midreset_pos", 96'({row_out, col_out}), 96'(0));
    rst = 1'b0;
    tick();
    check("postreset_pad_valid", 96'(valid_out), 96'(1));
    check("postreset_frame_start", 96'(frame_start), 96'(1));
    check("postreset_pos", 96'({row_out, col_out}), 96'(0));
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      tick();
      if (last_hs) word_in = word_in + 32'd1;
      if (valid_out && row_out == 3'd1 && col_out == 3'd1) done = 1'b1;
    end
    check("postreset_interior_seen", 96'(done), 96'(1));
    check("postreset_interior_data", data_out, {32'd56, 32'd55, 32'd54});

    // Channel ordering on pixel (1,2)
    idx = 0;
    word_in = pat[0];
    done = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      tick();
      if (last_hs) begin
        idx++;
        word_in = (idx < 3) ? pat[idx] : 32'd0;
      end
      if (valid_out) done = 1'b1;
    end
    check("order_seen", 96'(done), 96'(1));
    check("order_ch0", 96'(data_out[31:0]), 96'(32'hAAAA0000));
    check("order_ch1", 96'(data_out[63:32]), 96'(32'hBBBB0000));
    check("order_ch2", 96'(data_out[95:64]), 96'(32'hCCCC0000));
    check("order_pos", 96'({row_out, col_out}), 96'({3'd1, 3'd2}));

    // Unpadded 2x2 instance: every pixel interior, one every 4 cycles
    word_valid = 1'b0;
    word_valid0 = 1'b1;
    rst0 = 1'b0;
    #1;
    check("pad0_ready_after_reset", 96'(word_ready0), 96'(1));
    check("pad0_idle_valid", 96'(valid_out0), 96'(0));
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (last_hs0) word_in0 = word_in0 + 32'd1;
      check($sformatf("pad0_ready_k%0d", k), 96'(word_ready0), 96'((k % 4) != 3));
      check($sformatf("pad0_valid_k%0d", k), 96'(valid_out0), 96'((k % 4) == 0));
      if ((k % 4) == 0) begin
        n = k / 4;
        idx = (n - 1) % 4;
        check($sformatf("pad0_data_k%0d", k), data_out0,
              {32'(3 * n), 32'(3 * n - 1), 32'(3 * n - 2)});
        check($sformatf("pad0_pos_k%0d", k), 96'({row_out0, col_out0}),
              96'({1'(idx / 2), 1'(idx % 2)}));
        check($sformatf("pad0_fs_k%0d", k), 96'(frame_start0), 96'(idx == 0));
        check($sformatf("pad0_fe_k%0d", k), 96'(frame_end0), 96'(idx == 3));
      end else begin
        check($sformatf("pad0_idle_flags_k%0d", k),
              96'({frame_start0, frame_end0, row_out0, col_out0}), 96'(0));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
